// File: rtl/arb_mux_nto1_pkg.sv
// ---------------------------------------------------------------------------
// arb_mux_pkg
// Shared definitions for the N-to-1 arbitrated bus multiplexer:
//   ARB_DIRECT / ARB_RR : values of the 'mode' input
//   OH_MAX              : widest one-hot vector accepted by onehot2idx
//   onehot2idx()        : index of the set bit of a one-hot vector
// The output-stage record {valid, src, data} depends on the top-level
// parameters, so it is declared in the top module itself.
// ---------------------------------------------------------------------------
package arb_mux_pkg;

    localparam logic ARB_DIRECT = 1'b0;
    localparam logic ARB_RR     = 1'b1;

    localparam int OH_MAX = 256;

    // OR-reduction of the indices of all set bits; exact for one-hot input,
    // and zero for an all-zero vector.
    function automatic int unsigned onehot2idx(input logic [OH_MAX-1:0] oh);
        int unsigned idx;
        idx = 32'd0;
        for (int i = 0; i < OH_MAX; i++) begin
            idx = idx | (oh[i] ? unsigned'(i) : 32'd0);
        end
        return idx;
    endfunction

endpackage

// File: rtl/arb_mux_nto1_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// One-hot arbiter over N requesters.
//   RR_ARB_EN defined  : rotating priority; the search starts at an internal
//                        pointer that moves just past each winner.
//   RR_ARB_EN undefined: fixed priority, lowest index wins; no pointer and no
//                        clock/reset ports are built.
// Ports:
//   clk, rst_n : clock / async active-low reset (RR_ARB_EN only)
//   en         : grant permission; also the pointer update enable
//   req        : per-channel request
//   gnt        : one-hot grant, combinational, zero when en=0 or req=0
// ---------------------------------------------------------------------------
module rr_arbiter
    import arb_mux_pkg::*;
#(
    parameter  int N    = 8,
    localparam int SELW = $clog2(N)
) (
`ifdef RR_ARB_EN
    input  logic         clk,
    input  logic         rst_n,
`endif
    input  logic         en,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);

    logic [SELW-1:0] w_base;
    logic            w_found;

`ifdef RR_ARB_EN
    logic [SELW-1:0]   r_ptr;
    logic [OH_MAX-1:0] w_gnt_pad;
    logic [SELW-1:0]   w_idx;

    assign w_base    = r_ptr;
    assign w_gnt_pad = {{(OH_MAX-N){1'b0}}, gnt};
    assign w_idx     = SELW'(onehot2idx(w_gnt_pad));

    // Pointer moves one past the winner, wrapping at N-1 (N need not be 2^k)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (|gnt) begin
            r_ptr <= (int'(w_idx) == N-1) ? '0 : w_idx + 1'b1;
        end else begin
            r_ptr <= r_ptr;
        end
    end
`else
    assign w_base = '0;
`endif

    // Scan upward from the base index with wrap-around; first request wins
    always_comb begin
        int j;
        j       = 0;
        gnt     = '0;
        w_found = 1'b0;
        for (int k = 0; k < N; k++) begin
            j = (int'(w_base) + k) % N;
            if (en && !w_found && req[j]) begin
                gnt[j]  = 1'b1;
                w_found = 1'b1;
            end else begin
                w_found = w_found;
            end
        end
    end

endmodule

// File: rtl/arb_mux_nto1.sv
// ---------------------------------------------------------------------------
// arb_mux_nto1
// N-to-1 bus multiplexer with a single registered output stage and a
// valid/ready handshake. One channel is consumed per accepted cycle and its
// word appears on the output one cycle later.
// Build option: RR_ARB_EN selects round-robin arbitration for mode=1;
// without it mode=1 is fixed priority (lowest index wins).
// Ports:
//   Clk, Reset_n : clock (rising edge) / async active-low reset
//   mode         : 0 = direct select by 'sel', 1 = arbitrated
//   sel          : channel index for mode=0 (values >= N grant nothing)
//   req          : per-channel request
//   din          : channel data, channel i at din[i*WIDTH +: WIDTH]
//   gnt          : one-hot combinational grant (channel consumed this cycle)
//   out_valid    : output register holds a word
//   out_data     : registered word
//   out_src      : channel index that produced out_data
//   out_ready    : downstream accepts when out_valid && out_ready
// ---------------------------------------------------------------------------
module arb_mux_nto1
    import arb_mux_pkg::*;
#(
    parameter  int WIDTH = 16,
    parameter  int N     = 8,
    localparam int SELW  = $clog2(N)
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               mode,
    input  logic [SELW-1:0]    sel,
    input  logic [N-1:0]       req,
    input  logic [N*WIDTH-1:0] din,
    output logic [N-1:0]       gnt,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [SELW-1:0]    out_src,
    input  logic               out_ready
);

    typedef struct packed {
        logic             valid;
        logic [SELW-1:0]  src;
        logic [WIDTH-1:0] data;
    } out_stage_t;

    out_stage_t        r_stage;
    logic              w_ld;
    logic              w_sel_ok;
    logic              w_arb_en;
    logic              w_any;
    logic [N-1:0]      w_gnt_dir;
    logic [N-1:0]      w_gnt_arb;
    logic [N-1:0]      w_gnt;
    logic [OH_MAX-1:0] w_gnt_pad;
    logic [SELW-1:0]   w_win;

    // Reset_n is folded in so that gnt stays low while reset is asserted
    assign w_ld     = Reset_n && (!r_stage.valid || out_ready);
    assign w_sel_ok = (int'(sel) < N);
    assign w_arb_en = w_ld && (mode == ARB_RR);

    // Direct-select grant: only the addressed channel can be consumed
    always_comb begin
        w_gnt_dir = '0;
        if (w_ld && (mode == ARB_DIRECT) && w_sel_ok && req[sel]) begin
            w_gnt_dir[sel] = 1'b1;
        end else begin
            w_gnt_dir = '0;
        end
    end

    rr_arbiter #(.N(N)) u_arb (
`ifdef RR_ARB_EN
        .clk   (Clk),
        .rst_n (Reset_n),
`endif
        .en    (w_arb_en),
        .req   (req),
        .gnt   (w_gnt_arb)
    );

    assign w_gnt     = (mode == ARB_RR) ? w_gnt_arb : w_gnt_dir;
    assign w_any     = |w_gnt;
    assign w_gnt_pad = {{(OH_MAX-N){1'b0}}, w_gnt_arb};
    assign w_win     = (mode == ARB_RR) ? SELW'(onehot2idx(w_gnt_pad)) : sel;

    // Output stage: load on grant, empty on an idle load, hold while stalled
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_stage <= '0;
        end else if (w_ld) begin
            if (w_any) begin
                r_stage.valid <= 1'b1;
                r_stage.src   <= w_win;
                r_stage.data  <= din[w_win*WIDTH +: WIDTH];
            end else begin
                r_stage.valid <= 1'b0;
            end
        end else begin
            r_stage <= r_stage;
        end
    end

    assign gnt       = w_gnt;
    assign out_valid = r_stage.valid;
    assign out_data  = r_stage.data;
    assign out_src   = r_stage.src;

endmodule

// File: tb/tb_arb_mux_nto1.sv
module tb_arb_mux_nto1;

`ifdef RR_ARB_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic         clk;
    logic         Reset_n;

    logic         mode8, rdy8;
    logic [2:0]   sel8;
    logic [7:0]   req8, gnt8;
    logic [127:0] din8;
    logic         ov8;
    logic [15:0]  od8;
    logic [2:0]   os8;

    logic         mode5, rdy5;
    logic [2:0]   sel5;
    logic [4:0]   req5, gnt5;
    logic [79:0]  din5;
    logic         ov5;
    logic [15:0]  od5;
    logic [2:0]   os5;

    int n_chk  = 0;
    int n_fail = 0;

    arb_mux_nto1 #(.WIDTH(16), .N(8)) u_dut8 (
        .Clk(clk), .Reset_n(Reset_n), .mode(mode8), .sel(sel8), .req(req8),
        .din(din8), .gnt(gnt8), .out_valid(ov8), .out_data(od8),
        .out_src(os8), .out_ready(rdy8)
    );

    arb_mux_nto1 #(.WIDTH(16), .N(5)) u_dut5 (
        .Clk(clk), .Reset_n(Reset_n), .mode(mode5), .sel(sel5), .req(req5),
        .din(din5), .gnt(gnt5), .out_valid(ov5), .out_data(od5),
        .out_src(os5), .out_ready(rdy5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] pick(input logic [7:0] rr_v, input logic [7:0] fx_v);
        return RR ? rr_v : fx_v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model of the N=8 instance, checked every cycle at negedge.
    // Winner in arbitrated mode = set request with the smallest forward
    // distance from the pointer (round robin) or the lowest index (fixed).
    initial begin : model
        logic       m_valid;
        logic [15:0] m_data;
        logic [2:0] m_src;
        int         m_ptr;
        logic [7:0] e_gnt;
        logic       ld;
        int         win, bd, d;
        m_valid = 1'b0; m_data = 16'h0000; m_src = 3'd0; m_ptr = 0;
        forever begin
            @(negedge clk);
            e_gnt = 8'h00; win = -1; ld = 1'b0;
            if (!Reset_n) begin
                m_valid = 1'b0; m_data = 16'h0000; m_src = 3'd0; m_ptr = 0;
            end else begin
                ld = !m_valid || rdy8;
                if (ld && mode8 == 1'b0) begin
                    if (req8[sel8]) win = int'(sel8);
                end else if (ld) begin
                    bd = 8;
                    for (int i = 0; i < 8; i++) begin
                        d = RR ? ((i - m_ptr + 8) % 8) : i;
                        if (req8[i] && d < bd) begin bd = d; win = i; end
                    end
                end
                if (win >= 0) e_gnt[win] = 1'b1;
            end
            chk("mdl_gnt",   32'(gnt8), 32'(e_gnt));
            chk("mdl_valid", 32'(ov8),  32'(m_valid));
            chk("mdl_data",  32'(od8),  32'(m_data));
            chk("mdl_src",   32'(os8),  32'(m_src));
            @(posedge clk);
            if (Reset_n && ld) begin
                if (win >= 0) begin
                    m_valid = 1'b1;
                    m_data  = din8[win*16 +: 16];
                    m_src   = 3'(win);
                    if (mode8) m_ptr = (win + 1) % 8;
                end else begin
                    m_valid = 1'b0;
                end
            end
        end
    end

    initial begin : stim
        for (int i = 0; i < 8; i++) din8[i*16 +: 16] = 16'hA000 + 16'(i);
        din8[3*16 +: 16] = 16'hBEEF;
        for (int i = 0; i < 5; i++) din5[i*16 +: 16] = 16'hB000 + 16'(i);
        Reset_n = 1'b0;
        mode8 = 1'b0; sel8 = 3'd3; req8 = 8'hFF; rdy8 = 1'b1;
        mode5 = 1'b0; sel5 = 3'd0; req5 = 5'h00; rdy5 = 1'b1;

        // reset state, gnt held low despite a live request
        @(negedge clk);
        chk("rst_gnt",   32'(gnt8), 32'h0);
        chk("rst_valid", 32'(ov8),  32'h0);
        chk("rst_data",  32'(od8),  32'h0);
        chk("rst_src",   32'(os8),  32'h0);

        // direct select of channel 3
        step(); Reset_n = 1'b1;
        @(negedge clk); chk("dir_gnt", 32'(gnt8), 32'h08);
        step(); req8 = 8'h00;
        @(negedge clk);
        chk("dir_valid", 32'(ov8), 32'h1);
        chk("dir_data",  32'(od8), 32'hBEEF);
        chk("dir_src",   32'(os8), 32'h3);

        // arbitrated, req = 1000_0101 held
        step(); mode8 = 1'b1; req8 = 8'h85;
        @(negedge clk); chk("arb_g0", 32'(gnt8), 32'h01); chk("arb_drained", 32'(ov8), 32'h0);
        step(); @(negedge clk); chk("arb_g1", 32'(gnt8), 32'(pick(8'h04, 8'h01)));
        chk("arb_src1", 32'(os8), 32'h0);
        step(); @(negedge clk); chk("arb_g2", 32'(gnt8), 32'(pick(8'h80, 8'h01)));
        step(); @(negedge clk); chk("arb_g3", 32'(gnt8), 32'h01);

        // back-pressure for three cycles
        for (int c = 0; c < 3; c++) begin
            step(); rdy8 = 1'b0;
            @(negedge clk);
            chk("bp_gnt",  32'(gnt8), 32'h0);
            chk("bp_src",  32'(os8),  32'h0);
            chk("bp_data", 32'(od8),  32'hA000);
        end
        step(); rdy8 = 1'b1;
        @(negedge clk); chk("bp_rel_gnt", 32'(gnt8), 32'(pick(8'h04, 8'h01)));
        step(); @(negedge clk);
        chk("bp_nb_valid", 32'(ov8),  32'h1);
        chk("bp_nb_src",   32'(os8),  32'(pick(8'd2, 8'd0)));
        chk("bp_nb_data",  32'(od8),  32'(RR ? 16'hA002 : 16'hA000));
        chk("bp_nb_gnt",   32'(gnt8), 32'(pick(8'h80, 8'h01)));

        // reset mid-stream with a word held
        step(); Reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(ov8),  32'h0);
        chk("mid_rst_data",  32'(od8),  32'h0);
        chk("mid_rst_src",   32'(os8),  32'h0);
        chk("mid_rst_gnt",   32'(gnt8), 32'h0);
        step(); Reset_n = 1'b1;
        @(negedge clk); chk("post_rst_gnt", 32'(gnt8), 32'h01);

        // mode change takes effect at once; held word unaffected
        step(); mode8 = 1'b0; sel8 = 3'd5;
        @(negedge clk);
        chk("mc_gnt", 32'(gnt8), 32'h0);
        chk("mc_src", 32'(os8),  32'h0);
        step(); sel8 = 3'd7;
        @(negedge clk); chk("mc_gnt7", 32'(gnt8), 32'h80);
        step(); req8 = 8'h00;
        @(negedge clk);
        chk("mc_src7",  32'(os8), 32'h7);
        chk("mc_data7", 32'(od8), 32'hA007);

        // N=5: pointer wrap from 4 and drain
        step(); mode5 = 1'b1; req5 = 5'b01000;
        @(negedge clk); chk("n5_g3", 32'(gnt5), 32'h08);
        step(); req5 = 5'b00011;
        @(negedge clk);
        chk("n5_wrap_gnt", 32'(gnt5), 32'h01);
        chk("n5_src3",     32'(os5),  32'h3);
        chk("n5_data3",    32'(od5),  32'hB003);
        step();
        @(negedge clk);
        chk("n5_ptr1_gnt", 32'(gnt5), 32'(pick(8'h02, 8'h01)));
        chk("n5_src0",     32'(os5),  32'h0);
        step(); req5 = 5'b00000;
        @(negedge clk);
        chk("n5_idle_gnt", 32'(gnt5), 32'h0);
        chk("n5_last_src", 32'(os5),  32'(pick(8'd1, 8'd0)));

        // N=5: select code beyond the channel count
        step(); mode5 = 1'b0; sel5 = 3'd6; req5 = 5'h1F;
        @(negedge clk);
        chk("n5_bad_gnt",  32'(gnt5), 32'h0);
        chk("n5_drain",    32'(ov5),  32'h0);
        step();
        @(negedge clk);
        chk("n5_bad_gnt2", 32'(gnt5), 32'h0);
        chk("n5_bad_valid", 32'(ov5), 32'h0);
        step(); sel5 = 3'd4;
        @(negedge clk); chk("n5_sel4_gnt", 32'(gnt5), 32'h10);
        step(); req5 = 5'h00;
        @(negedge clk);
        chk("n5_sel4_valid", 32'(ov5), 32'h1);
        chk("n5_sel4_src",   32'(os5), 32'h4);
        chk("n5_sel4_data",  32'(od5), 32'hB004);

        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
